// File: rtl/pay_accum.sv
// Vending machine payment accumulator: prices the current selection, collects
// coins, and pays out change on a successful confirm or a full refund on abort.
module pay_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] area_flag,
  input  logic [3:0] goods_index,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [7:0] price,
  output logic [7:0] paid,
  output logic       enough_flag,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       refund_valid,
  output logic       coin_reject
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] price_q, price_d;
  logic [7:0] paid_q, paid_d;
  logic [7:0] change_q, change_d;
  logic       changeValid_q, changeValid_d;
  logic       refundValid_q, refundValid_d;
  logic       coinReject_q, coinReject_d;

  logic [8:0] coinSum;
  logic [8:0] paidPlusSum;
  logic       coinAny;
  logic       enough;

  always_comb begin
    price_d = 8'd0;
    if (goods_index >= 4'd1 && goods_index <= 4'd4)
      price_d = 8'd3;
    else if (goods_index >= 4'd5 && goods_index <= 4'd8)
      price_d = 8'd5;
    else if (goods_index >= 4'd9 && goods_index <= 4'd12)
      price_d = 8'd8;
  end

  always_comb begin
    coinSum = 9'd0;
    if (coin_1)  coinSum = coinSum + 9'd1;
    if (coin_5)  coinSum = coinSum + 9'd5;
    if (coin_10) coinSum = coinSum + 9'd10;
  end

  assign coinAny     = coin_1 | coin_5 | coin_10;
  // Widened to 9 bits so an overflowing insert is seen rather than wrapped.
  assign paidPlusSum = {1'b0, paid_q} + coinSum;
  assign enough      = (state_q == COLLECT) && (price_q != 8'd0) && (paid_q >= price_q);

  // Coins are rejected by default; only a clean COLLECT cycle accepts them.
  always_comb begin
    state_d       = state_q;
    paid_d        = paid_q;
    change_d      = change_q;
    changeValid_d = 1'b0;
    refundValid_d = 1'b0;
    coinReject_d  = coinAny;
    case (state_q)
      IDLE: begin
        if (goods_index != 4'd0)
          state_d = COLLECT;
      end
      COLLECT: begin
        if (area_flag == 5'd17) begin
          if (enough) begin
            state_d       = DONE;
            change_d      = paid_q - price_q;
            changeValid_d = 1'b1;
          end else begin
            state_d       = REFUND;
            change_d      = paid_q;
            refundValid_d = 1'b1;
          end
        end else if (area_flag == 5'd18 || goods_index == 4'd0) begin
          state_d       = REFUND;
          change_d      = paid_q;
          refundValid_d = 1'b1;
        end else if (paidPlusSum <= 9'd255) begin
          paid_d       = paidPlusSum[7:0];
          coinReject_d = 1'b0;
        end
      end
      DONE, REFUND: begin
        paid_d  = 8'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      price_q       <= 8'd0;
      paid_q        <= 8'd0;
      change_q      <= 8'd0;
      changeValid_q <= 1'b0;
      refundValid_q <= 1'b0;
      coinReject_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      price_q       <= price_d;
      paid_q        <= paid_d;
      change_q      <= change_d;
      changeValid_q <= changeValid_d;
      refundValid_q <= refundValid_d;
      coinReject_q  <= coinReject_d;
    end
  end

  assign price        = price_q;
  assign paid         = paid_q;
  assign enough_flag  = enough;
  assign change       = change_q;
  assign change_valid = changeValid_q;
  assign refund_valid = refundValid_q;
  assign coin_reject  = coinReject_q;

endmodule

// File: doc/pay_accum.md
# pay_accum

Payment accumulator for the vending machine. It sits beside `goods_choose` and consumes its `goods_index`: it looks up the selected item's price, counts inserted coins and drives the `enough_flag` that `goods_choose` samples on confirm. On confirm it issues change. On cancel, failed confirm or de-selection it refunds the full paid amount.

## Interface
- No parameters. The price table is fixed.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `area_flag`  in  5  keypad code, same bus that feeds `goods_choose`:
  - 1..12 select an item
  - 17 confirm
  - 18 cancel
- `goods_index`  in  4  selected item from `goods_choose`; 0 means none.
- `coin_1`, `coin_5`, `coin_10`  in  1 each  one-cycle coin pulses worth 1, 5 and 10 yuan.
- `price`  out  8  registered price of the current selection.
- `paid`  out  8  registered accumulated amount.
- `enough_flag`  out  1  combinational: `state==COLLECT && price!=0 && paid>=price`.
- `change`  out  8  registered payout amount; valid while `change_valid` or `refund_valid` is high.
- `change_valid`  out  1  one-cycle pulse: sale completed, `change` = `paid − price`.
- `refund_valid`  out  1  one-cycle pulse: sale aborted, `change` = full `paid`.
- `coin_reject`  out  1  one-cycle pulse: at least one coin in this cycle was not accepted.

## Operation
- Price table, applied to `goods_index`:
  - 1..4 → 3
  - 5..8 → 5
  - 9..12 → 8
  - 0 and 13..15 → 0
- `price` register loads the table value every cycle.
- States: IDLE, COLLECT, DONE, REFUND. The 2-bit state register resets to IDLE.
- IDLE:
  - `goods_index != 0` → COLLECT.
  - All coins are rejected.
- COLLECT:
  - Coin sum = 1·`coin_1` + 5·`coin_5` + 10·`coin_10`; simultaneous pulses are summed.
  - If `paid + sum <= 255`, `paid += sum`.
  - Otherwise `paid` is unchanged and `coin_reject` pulses. The whole cycle's sum is rejected (no partial accept).
  - `area_flag==17 && enough_flag` → DONE; `change <= paid − price`.
  - `area_flag==17 && !enough_flag` → REFUND; `change <= paid`.
  - `area_flag==18` → REFUND; `change <= paid`.
  - `goods_index==0` (no 17/18 that cycle) → REFUND; `change <= paid`.
  - Priority order: 17, then 18, then `goods_index==0`, then coins.
  - Coins arriving in the same cycle as any exit condition are rejected.
  - A change of `goods_index` to another non-zero value keeps `paid`. Only `price` reloads.
- DONE:
  - `change_valid` = 1 for this single cycle.
  - `paid <= 0`.
  - Coins rejected.
  - → IDLE.
- REFUND:
  - `refund_valid` = 1 for this single cycle.
  - `paid <= 0`.
  - Coins rejected.
  - → IDLE.
- `change` holds its last value until the next DONE/REFUND entry.
- Arithmetic is 8-bit unsigned. The `paid + sum` compare is done in 9 bits. `paid − price` never underflows because DONE requires `paid >= price`.

## Timing
- Reset values: state IDLE; `paid`, `price`, `change` = 0; `change_valid`, `refund_valid`, `coin_reject` = 0; hence `enough_flag` = 0.
- Reset mid-operation drops `paid` to 0 immediately, with no refund pulse.
- Coin pulse in cycle N → `paid` updated after edge N. `enough_flag` reflects it in cycle N+1.
- `goods_index` change in cycle N → `price` valid in cycle N+1. `enough_flag` can therefore lag a selection change by one cycle.
- Confirm with `area_flag==17` in cycle N:
  - `enough_flag` in cycle N is the same value `goods_choose` sees.
  - Enter DONE/REFUND at edge N; `change_valid`/`refund_valid` high in cycle N+1.
  - Back to IDLE at edge N+1.
- `coin_reject` is registered: it is high in the cycle after the rejected coin.
- A new selection is needed to re-enter COLLECT. It is accepted in cycle N+2 or later.

## Test plan
- Reset, then select item 2 (price 3), insert `coin_1` ×3 → `paid` = 3, `enough_flag` = 1 in the cycle after the 3rd coin; `area_flag` = 17 → `change_valid` pulse with `change` = 0, `paid` = 0.
- Select 10 (price 8), insert `coin_10` → `enough_flag` = 1; confirm → `change` = 2 with `change_valid`.
- Select 6 (price 5), insert `coin_1` ×2, `area_flag` = 17 → `refund_valid` with `change` = 2, no `change_valid`. Repeat the case with `area_flag` = 18 → same response.
- Select 3, insert 5, reselect 9 → `paid` stays 5, `price` becomes 8, `enough_flag` = 0; add `coin_5` → `paid` = 10, confirm → `change` = 2.
- Simultaneous `coin_1` + `coin_5` + `coin_10` → `paid` += 16. Fill `paid` to 250, then `coin_10` → `coin_reject` pulse, `paid` stays 250. Coin while IDLE → `coin_reject` pulse, `paid` stays 0.
- Assert `rst` with `paid` = 7 in COLLECT → all outputs 0 asynchronously, no refund pulse; after release, state is IDLE.
